ycr_tcm_mem_ctrl: RTL and testbench
===================================

YCR_TCM_MEM_CTRL -- requirements
Module: ycr_tcm_mem_ctrl

Interface
REQ-001 SHALL have parameter YCR_WIDTH, default 32, memory data width in bits (only 32 supported).
REQ-002 SHALL have parameter YCR_SIZE, default 65536, memory size in bytes; word count WORDS = YCR_SIZE/4.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port core_req  input  1  core request valid.
REQ-006 SHALL have port core_cmd  input  1  0 = read, 1 = write.
REQ-007 SHALL have port core_width  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port core_addr  input  $clog2(YCR_SIZE)  byte address.
REQ-009 SHALL have port core_wdata  input  32  write data, LSB-aligned.
REQ-010 SHALL have port core_req_ack  output  1  request accepted this cycle.
REQ-011 SHALL have port core_resp_vld  output  1  response valid, one-cycle pulse.
REQ-012 SHALL have port core_resp_err  output  1  response is error; qualified by core_resp_vld.
REQ-013 SHALL have port core_rdata  output  32  read data, LSB-aligned, zero-extended.
REQ-014 SHALL have ports mem_ren (1), mem_wen (1), mem_wben (4), mem_addr ($clog2(YCR_SIZE)-2), mem_wdata (32), all output; mem_rdata (32) input; these drive the memory read/write port, which has one-cycle registered read latency.
REQ-015 SHALL have port init_done  output  1  memory initialisation complete.

Function
REQ-016 SHALL implement FSM states IDLE, RESP (plus INIT when YCR_TCM_INIT_EN is defined).
REQ-017 core_req_ack SHALL be 1 combinationally only when state is IDLE and init_done is 1; a request is accepted when core_req and core_req_ack are both 1.
REQ-018 On acceptance, SHALL go IDLE -> RESP; in RESP, SHALL assert core_resp_vld for exactly one cycle and return to IDLE; core_req_ack is 0 in RESP (max one access per 2 cycles).
REQ-019 Access misaligned if width 01 with addr[0]=1, width 10 with addr[1:0]!=0, or width 11; misaligned access SHALL produce no memory strobe, then core_resp_err=1 and core_rdata=0 in RESP.
REQ-020 Aligned read: in the acceptance cycle, SHALL drive mem_ren=1 and mem_addr=core_addr[MSB:2]; in RESP, core_rdata = (mem_rdata >> 8*offset) masked to width (byte 0xFF, half 0xFFFF, word all).
REQ-021 Aligned write: in the acceptance cycle, SHALL drive mem_wen=1; mem_wben = 0001<<off (byte), 0011<<off (half), 1111 (word); mem_wdata = core_wdata replicated per lane (byte x4, half x2, word as-is).
REQ-022 offset, width and error flag SHALL be registered at acceptance for use in RESP.
REQ-023 mem_ren, mem_wen and mem_wben SHALL be 0 in every cycle without an accepted aligned access (except INIT sweep); mem_addr and mem_wdata are don't-care then.
REQ-024 Write responses SHALL have core_rdata=0, core_resp_err=0.
REQ-025 core_resp_vld/err/rdata SHALL be 0 outside RESP.

Reset
REQ-026 rst SHALL force state to IDLE (or INIT when macro defined), core_resp_vld=0, core_resp_err=0, core_rdata=0, all memory strobes 0.
REQ-027 rst asserted while in RESP SHALL drop the pending response; no core_resp_vld follows.
REQ-028 rst during INIT SHALL restart the sweep from word 0.

Configuration
REQ-029 Macro YCR_TCM_INIT_EN defined: after reset, SHALL enter INIT, writing 0 to words 0..WORDS-1, one per cycle (mem_wen=1, mem_wben=1111, mem_wdata=0, mem_addr=counter), init_done=0, core_req_ack=0; after word WORDS-1, SHALL set init_done=1 and go IDLE.
REQ-030 Macro YCR_TCM_INIT_EN undefined: no INIT state or counter; init_done SHALL be constant 1; first request acceptable the cycle after rst deasserts.

Verification
REQ-031 Word write addr 0x0010 data 0xDEADBEEF -> mem_wen=1, mem_wben=1111, mem_addr=0x004; next cycle resp_vld=1, err=0.
REQ-032 Byte write addr 0x0013 data 0x000000A5 -> mem_wben=1000, mem_wdata=0xA5A5A5A5; then byte read 0x0013 -> core_rdata=0x000000A5.
REQ-033 Half read addr 0x0012 with mem_rdata=0x12345678 -> mem_ren=1 in accept cycle, next cycle core_rdata=0x00001234, err=0.
REQ-034 Word read addr 0x0002 -> no mem_ren, next cycle resp_vld=1, err=1, rdata=0; width 11 likewise errors.
REQ-035 Continuous core_req back-to-back -> core_req_ack alternates 1,0; rst asserted in RESP -> no resp_vld.
REQ-036 With YCR_TCM_INIT_EN, YCR_SIZE=64: rst released -> 16 consecutive mem_wen cycles addr 0..15, then init_done=1 and core_req_ack=1.

Source files
------------

// File: rtl/ycr_tcm_mem_ctrl.sv
// Tightly-coupled memory controller: byte/half/word core accesses onto a 32-bit memory port.
// Optional power-up zero sweep enabled by defining YCR_TCM_INIT_EN.
module ycr_tcm_mem_ctrl #(
  parameter int YCR_WIDTH = 32,
  parameter int YCR_SIZE  = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_req,
  input  logic                          core_cmd,
  input  logic [1:0]                    core_width,
  input  logic [$clog2(YCR_SIZE)-1:0]   core_addr,
  input  logic [YCR_WIDTH-1:0]          core_wdata,
  output logic                          core_req_ack,
  output logic                          core_resp_vld,
  output logic                          core_resp_err,
  output logic [YCR_WIDTH-1:0]          core_rdata,
  output logic                          mem_ren,
  output logic                          mem_wen,
  output logic [3:0]                    mem_wben,
  output logic [$clog2(YCR_SIZE)-3:0]   mem_addr,
  output logic [YCR_WIDTH-1:0]          mem_wdata,
  input  logic [YCR_WIDTH-1:0]          mem_rdata,
  output logic                          init_done
);

  // state  | meaning
  // IDLE   | ready to accept one core request
  // RESP   | response cycle for the access accepted last cycle
  // INIT   | zero sweep over every memory word (YCR_TCM_INIT_EN only)
  localparam int AW  = $clog2(YCR_SIZE);
  localparam int MAW = AW - 2;

`ifdef YCR_TCM_INIT_EN
  localparam int WORDS = YCR_SIZE / 4;
  localparam logic [MAW-1:0] LAST_WORD = MAW'(WORDS - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd1, S_INIT = 2'd2} state_t;
  localparam state_t RST_STATE = S_INIT;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd1} state_t;
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_off;
  logic [1:0]      r_width;
  logic            r_err;
  logic            r_cmd;
  logic [1:0]      w_off;
  logic            w_mis;
  logic            w_accept;
  logic [4:0]      w_shamt;
  logic [YCR_WIDTH-1:0] w_shift;

  assign w_off    = core_addr[1:0];
  assign w_mis    = (core_width == 2'b11) ||
                    ((core_width == 2'b01) && w_off[0]) ||
                    ((core_width == 2'b10) && (w_off != 2'b00));
  assign core_req_ack = (r_state == S_IDLE) && init_done && !rst;
  assign w_accept = core_req && core_req_ack;
  assign w_shamt  = {r_off, 3'b000};
  assign w_shift  = mem_rdata >> w_shamt;

`ifdef YCR_TCM_INIT_EN
  logic [MAW-1:0] r_init_cnt;
  logic           r_init_done;

  assign init_done = r_init_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == LAST_WORD) r_init_done <= 1'b1;
    end
  end
`else
  assign init_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off   <= 2'b00;
      r_width <= 2'b00;
      r_err   <= 1'b0;
      r_cmd   <= 1'b0;
    end else if (w_accept) begin
      r_off   <= w_off;
      r_width <= core_width;
      r_err   <= w_mis;
      r_cmd   <= core_cmd;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_wben      = 4'b0000;
    mem_addr      = core_addr[AW-1:2];
    mem_wdata     = core_wdata;
    core_resp_vld = 1'b0;
    core_resp_err = 1'b0;
    core_rdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RESP;
          if (!w_mis) begin
            mem_ren = !core_cmd;
            mem_wen = core_cmd;
            if (core_cmd) begin
              // Replicate narrow data on every lane so the strobes alone pick the target bytes.
              case (core_width)
                2'b00: begin
                  mem_wben  = 4'b0001 << w_off;
                  mem_wdata = {4{core_wdata[7:0]}};
                end
                2'b01: begin
                  mem_wben  = 4'b0011 << w_off;
                  mem_wdata = {2{core_wdata[15:0]}};
                end
                default: mem_wben = 4'b1111;
              endcase
            end
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        if (!rst) begin
          core_resp_vld = 1'b1;
          core_resp_err = r_err;
          if (!r_err && !r_cmd) begin
            case (r_width)
              2'b00:   core_rdata = {{(YCR_WIDTH-8){1'b0}},  w_shift[7:0]};
              2'b01:   core_rdata = {{(YCR_WIDTH-16){1'b0}}, w_shift[15:0]};
              default: core_rdata = w_shift;
            endcase
          end
        end
      end
`ifdef YCR_TCM_INIT_EN
      S_INIT: begin
        if (!rst) begin
          mem_wen   = 1'b1;
          mem_wben  = 4'b1111;
          mem_wdata = '0;
          mem_addr  = r_init_cnt;
        end
        if (r_init_cnt == LAST_WORD) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ycr_tcm_mem_ctrl.sv
// Scoreboard bench for ycr_tcm_mem_ctrl with a byte-array reference memory and a word-wide model RAM.
module tb_ycr_tcm_mem_ctrl;
  localparam int SIZE = 64;
  localparam int NW   = SIZE / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_cmd = 1'b0;
  logic [1:0]  core_width = 2'b00;
  logic [5:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_req_ack, core_resp_vld, core_resp_err;
  logic [31:0] core_rdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_wben;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        init_done;

  always #5 clk = ~clk;

  ycr_tcm_mem_ctrl #(.YCR_WIDTH(32), .YCR_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_req_ack(core_req_ack), .core_resp_vld(core_resp_vld),
    .core_resp_err(core_resp_err), .core_rdata(core_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wben(mem_wben),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done)
  );

  logic [31:0] tbmem [NW];
  logic [7:0]  ref_mem [SIZE];

  always @(posedge clk) begin
    if (mem_wen)
      for (int i = 0; i < 4; i++)
        if (mem_wben[i]) tbmem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
    if (mem_ren) mem_rdata <= tbmem[mem_addr];
  end

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic last_acc = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: responses must arrive exactly one cycle after acceptance, in order.
  initial forever begin
    @(negedge clk);
    #2;
    if (core_resp_vld === 1'b1) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=vld required=no_resp cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", 32'(core_resp_err), 32'(e.err));
        chk("resp_rdata", core_rdata, e.rdata);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      void'(sb.pop_front());
      checks++; errors++;
      $display("FAIL missing_resp actual=no_vld required=vld cyc=%0d", cyc);
    end else begin
      chk("idle_rdata", core_rdata, 32'd0);
      chk("idle_err", 32'(core_resp_err), 32'd0);
    end
  end

  task automatic issue(input logic req, input logic cmd, input logic [1:0] w,
                       input logic [5:0] a, input logic [31:0] d);
    logic        mis, exp_ack, acc;
    int          nb, off;
    logic [31:0] val, rep;
    exp_t        e;
    @(negedge clk);
    core_req = req; core_cmd = cmd; core_width = w; core_addr = a; core_wdata = d;
    #1;
    exp_ack = !last_acc;
    chk("req_ack", 32'(core_req_ack), 32'(exp_ack));
    acc = req && exp_ack;
    mis = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
    off = int'(a) % 4;
    nb  = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    val = '0;
    if (acc && !mis) begin
      chk("mem_addr", 32'(mem_addr), 32'(int'(a) / 4));
      if (cmd) begin
        chk("mem_wen", 32'(mem_wen), 32'd1);
        chk("mem_ren", 32'(mem_ren), 32'd0);
        chk("mem_wben", 32'(mem_wben), 32'(((1 << nb) - 1) << off));
        for (int i = 0; i < 4; i++) rep[8*i +: 8] = d[8*(i % nb) +: 8];
        chk("mem_wdata", mem_wdata, rep);
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
      end else begin
        chk("mem_ren", 32'(mem_ren), 32'd1);
        chk("mem_wen", 32'(mem_wen), 32'd0);
        chk("mem_wben", 32'(mem_wben), 32'd0);
        for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8*i));
      end
    end else begin
      chk("no_ren", 32'(mem_ren), 32'd0);
      chk("no_wen", 32'(mem_wen), 32'd0);
      chk("no_wben", 32'(mem_wben), 32'd0);
    end
    if (acc) begin
      e.due = cyc + 1; e.err = mis; e.rdata = val;
      sb.push_back(e);
    end
    last_acc = acc;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; core_req = 1'b0;
    #1;
    sb.delete();
    for (int k = 0; k < n; k++) begin
      if (k != 0) begin @(negedge clk); #1; end
      chk("rst_vld", 32'(core_resp_vld), 32'd0);
      chk("rst_ren", 32'(mem_ren), 32'd0);
      chk("rst_wen", 32'(mem_wen), 32'd0);
      chk("rst_wben", 32'(mem_wben), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    last_acc = 1'b0;
`ifdef YCR_TCM_INIT_EN
    #1;
    for (int k = 0; k < NW; k++) begin
      if (k != 0) begin @(negedge clk); #1; end
      chk("init_wen", 32'(mem_wen), 32'd1);
      chk("init_addr", 32'(mem_addr), 32'(k));
      chk("init_wben", 32'(mem_wben), 32'hF);
      chk("init_wdata", mem_wdata, 32'd0);
      chk("init_ack", 32'(core_req_ack), 32'd0);
      chk("init_done_lo", 32'(init_done), 32'd0);
    end
    @(negedge clk); #1;
    chk("init_done_hi", 32'(init_done), 32'd1);
    chk("init_ack_hi", 32'(core_req_ack), 32'd1);
    for (int i = 0; i < SIZE; i++) ref_mem[i] = 8'h00;
`else
    #1;
    chk("init_done", 32'(init_done), 32'd1);
`endif
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      tbmem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tbmem[i][8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3);

    issue(1, 1, 2'b10, 6'h10, 32'hDEADBEEF);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 1, 2'b00, 6'h13, 32'h000000A5);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 0, 2'b00, 6'h13, 32'h0);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 1, 2'b10, 6'h10, 32'h12345678);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 0, 2'b01, 6'h12, 32'h0);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 0, 2'b10, 6'h02, 32'h0);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 0, 2'b11, 6'h00, 32'h0);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 1, 2'b01, 6'h21, 32'hCAFE);

    for (int k = 0; k < 10; k++)
      issue(1, 1'($urandom), 2'($urandom_range(0, 2)), 6'($urandom), $urandom);

    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(0, 0, 2'b00, 6'h00, 32'h0);
    issue(1, 0, 2'b10, 6'h08, 32'h0);
    do_reset(2);

    for (int k = 0; k < 400; k++) begin
      logic [1:0] w;
      logic [5:0] a;
      w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = 6'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'b01) a[0] = 1'b0;
        if (w == 2'b10) a[1:0] = 2'b00;
      end
      issue(($urandom_range(0, 3) != 0), 1'($urandom), w, a, $urandom);
    end

    issue(0, 0, 2'b00, 6'h00, 32'h0);
    repeat (4) @(negedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
